led_chain_driver: RTL

- Host-side frame sequencer for the daisy-chained three-LED PWM nodes. Each node consumes 12 bits and forwards the rest.
- Holds one 12-bit colour word per node in a small register file.
- On request, serialises all words onto the single chain data line using pulse-width bit encoding.
- Then drives a low latch gap so every node transfers its received word to its PWM outputs.

---
 rtl/led_chain_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/led_chain_driver.sv
// Frame sequencer for daisy-chained 12-bit PWM LED nodes.
// Optional idle auto-refresh: define LED_CHAIN_AUTO_REFRESH_EN.
module led_chain_driver #(
  parameter int NUM_NODES      = 4,
  parameter int AW             = 3,
  parameter int T_BIT          = 16,
  parameter int T0H            = 3,
  parameter int T1H            = 9,
  parameter int GAP_CYCLES     = 128,
  parameter int REFRESH_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          dout
);

  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SW = $clog2(T_BIT);
  localparam int GW = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic [11:0]   mem [NUM_NODES];
  logic [NW-1:0] node;
  logic [3:0]    bit_i;
  logic [SW-1:0] slot;
  logic [GW-1:0] gap_cnt;
  logic          quiet;

  logic          wr_ok;
  logic          go;
  logic          refresh_hit;
  logic          slot_last;
  logic          bit_last;
  logic          node_last;
  logic          frame_last;
  logic [SW-1:0] n_slot;
  logic [3:0]    n_bit;
  logic [NW-1:0] n_node;
  logic          n_val;
  logic          n_dout;

  assign wr_ok = wr_en && (state == IDLE) &&
                 ({1'b0, wr_addr} < (AW+1)'(NUM_NODES));
  assign go    = (state == IDLE) && (start || refresh_hit);

  // Look one clock ahead so dout is registered at the slot position it shows.
  always_comb begin
    slot_last  = (slot == SW'(T_BIT - 1));
    bit_last   = (bit_i == 4'd0);
    node_last  = (node == NW'(NUM_NODES - 1));
    frame_last = slot_last && bit_last && node_last;
    n_slot     = slot_last ? '0 : slot + 1'b1;
    n_bit      = bit_i;
    n_node     = node;
    if (slot_last) begin
      n_bit = bit_last ? 4'd11 : bit_i - 4'd1;
      if (bit_last && !node_last) n_node = node + 1'b1;
    end
    n_val  = mem[n_node][n_bit];
    n_dout = n_val ? (n_slot < SW'(T1H)) : (n_slot < SW'(T0H));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= GAP;
      busy    <= 1'b1;
      done    <= 1'b0;
      dout    <= 1'b0;
      quiet   <= 1'b1;
      gap_cnt <= '0;
      node    <= '0;
      bit_i   <= 4'd11;
      slot    <= '0;
      for (int i = 0; i < NUM_NODES; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (wr_ok) mem[wr_addr[NW-1:0]] <= wr_data;
      unique case (state)
        IDLE: begin
          dout <= 1'b0;
          if (go) begin
            state <= SEND;
            busy  <= 1'b1;
            node  <= '0;
            bit_i <= 4'd11;
            slot  <= '0;
            dout  <= 1'b1;
          end
        end
        SEND: begin
          if (frame_last) begin
            state   <= GAP;
            gap_cnt <= '0;
            dout    <= 1'b0;
          end else begin
            slot  <= n_slot;
            bit_i <= n_bit;
            node  <= n_node;
            dout  <= n_dout;
          end
        end
        GAP: begin
          dout <= 1'b0;
          if (gap_cnt == GW'(GAP_CYCLES - 2) && !quiet) done <= 1'b1;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            quiet <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= GAP;
          busy  <= 1'b1;
          dout  <= 1'b0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

`ifdef LED_CHAIN_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES);

  logic [RW-1:0] idle_cnt;

  assign refresh_hit = (state == IDLE) &&
                       (idle_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != IDLE || wr_ok || start || refresh_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign refresh_hit = 1'b0;
`endif

endmodule
